// File: rtl/fifo_drain_checker.sv
// -----------------------------------------------------------------------------
// fifo_drain_checker
//
// Read-side consumer for an 8-bit single-clock FIFO running in normal
// (non-show-ahead) mode. The block sits idle until the FIFO reports full. It
// then drains the FIFO to empty in a single burst and checks every word
// against an increment-by-one sequence (mod 2^DATA_W). It also keeps counts of
// completed bursts, words in the current burst, and data mismatches.
//
// Optional feature macro: FIFO_CHK_STOP_ON_ERR_EN
//   Defined     : the first mismatch parks the FSM in HALT. Reading stops,
//                 busy stays high, and no further bursts complete until reset.
//   Not defined : no HALT state. Mismatches are counted and draining goes on.
//
// Parameters
//   DATA_W        width of the FIFO data word
//   CNT_W         width of the word / burst / error counters
//
// Ports
//   i_clk         single clock, rising edge (also the FIFO read clock)
//   i_rst_n       synchronous active-low reset
//   i_rdfull      FIFO read-side full flag
//   i_rdempty     FIFO read-side empty flag
//   i_q           FIFO read data, valid one cycle after o_rdreq
//   o_rdreq       FIFO read request (gated by i_rdempty, never underflows)
//   o_busy        high in every state except IDLE
//   o_burst_done  one-cycle pulse when a burst completes
//   o_err         one-cycle pulse for each data mismatch
//   o_last_data   last word read from the FIFO
//   o_word_cnt    words read in the current or most recent burst (saturating)
//   o_burst_cnt   completed bursts (saturating)
//   o_err_cnt     total mismatches (saturating)
// -----------------------------------------------------------------------------
module fifo_drain_checker #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rdfull,
  input  logic              i_rdempty,
  input  logic [DATA_W-1:0] i_q,
  output logic              o_rdreq,
  output logic              o_busy,
  output logic              o_burst_done,
  output logic              o_err,
  output logic [DATA_W-1:0] o_last_data,
  output logic [CNT_W-1:0]  o_word_cnt,
  output logic [CNT_W-1:0]  o_burst_cnt,
  output logic [CNT_W-1:0]  o_err_cnt
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_TAIL  = 3'd2,
`ifdef FIFO_CHK_STOP_ON_ERR_EN
    S_DONE  = 3'd3,
    S_HALT  = 3'd4
`else
    S_DONE  = 3'd3
`endif
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t              r_state;
  logic                r_rd_vld;     // o_rdreq delayed by one cycle: i_q is valid
  logic                r_first;      // next received word is the first of a burst
  logic [DATA_W-1:0]   r_exp;        // expected value of the next word
  logic                r_err;
  logic [DATA_W-1:0]   r_last_data;
  logic [CNT_W-1:0]    r_word_cnt;
  logic [CNT_W-1:0]    r_burst_cnt;
  logic [CNT_W-1:0]    r_err_cnt;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  state_t              w_state_next;
  logic                w_rdreq;
  logic                w_busy;
  logic                w_burst_done;
  logic                w_burst_start;
  logic                w_check;
  logic                w_mismatch;
  logic [DATA_W-1:0]   w_q_inc;
  logic                w_word_sat;
  logic                w_burst_sat;
  logic                w_err_sat;

  assign w_burst_start = (r_state == S_IDLE) && i_rdfull;
  assign w_q_inc       = i_q + 1'b1;

  // A received word is checked unless it opens the burst. In the stop-on-error
  // build, a word that lands after HALT was entered is only captured.
`ifdef FIFO_CHK_STOP_ON_ERR_EN
  assign w_check    = r_rd_vld && !r_first && (r_state != S_HALT);
`else
  assign w_check    = r_rd_vld && !r_first;
`endif
  assign w_mismatch = w_check && (i_q != r_exp);

  assign w_word_sat  = &r_word_cnt;
  assign w_burst_sat = &r_burst_cnt;
  assign w_err_sat   = &r_err_cnt;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and Moore-style control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_rdreq      = 1'b0;
    w_busy       = 1'b1;
    w_burst_done = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (i_rdfull) begin
          w_state_next = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // Gating by empty is what keeps the FIFO from underflowing.
        w_rdreq = !i_rdempty;
        if (i_rdempty) begin
          w_state_next = S_TAIL;
        end
      end

      // One spare cycle so the word requested last in DRAIN has been checked
      // before the burst is reported complete.
      S_TAIL: begin
        w_state_next = S_DONE;
      end

      S_DONE: begin
        w_burst_done = 1'b1;
        w_state_next = S_IDLE;
      end

`ifdef FIFO_CHK_STOP_ON_ERR_EN
      // Terminal until reset.
      S_HALT: begin
        w_state_next = S_HALT;
      end
`endif

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

`ifdef FIFO_CHK_STOP_ON_ERR_EN
    // The first mismatch overrides the normal flow while reading.
    if (w_mismatch && ((r_state == S_DRAIN) || (r_state == S_TAIL))) begin
      w_state_next = S_HALT;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Read pipeline and sequence checker
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      // Dropping r_rd_vld discards any word that is still in flight.
      r_rd_vld    <= 1'b0;
      r_first     <= 1'b0;
      r_exp       <= '0;
      r_err       <= 1'b0;
      r_last_data <= '0;
      r_word_cnt  <= '0;
    end else begin
      r_rd_vld <= w_rdreq;
      r_err    <= w_mismatch;

      if (w_burst_start) begin
        // Only reachable from IDLE, where no read can be in flight.
        r_word_cnt <= '0;
        r_first    <= 1'b1;
      end else if (r_rd_vld) begin
        r_last_data <= i_q;
        if (!w_word_sat) begin
          r_word_cnt <= r_word_cnt + 1'b1;
        end
        r_first <= 1'b0;
        // Always follow the received value so a single corrupted word
        // costs at most two mismatches rather than the rest of the burst.
        r_exp   <= w_q_inc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Burst and error statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_burst_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_burst_done && !w_burst_sat) begin
        r_burst_cnt <= r_burst_cnt + 1'b1;
      end
      if (w_mismatch && !w_err_sat) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_rdreq      = w_rdreq;
  assign o_busy       = w_busy;
  assign o_burst_done = w_burst_done;
  assign o_err        = r_err;
  assign o_last_data  = r_last_data;
  assign o_word_cnt   = r_word_cnt;
  assign o_burst_cnt  = r_burst_cnt;
  assign o_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_fifo_drain_checker.sv
// -----------------------------------------------------------------------------
// tb_fifo_drain_checker
//
// Directed bench for fifo_drain_checker. A behavioural 256-deep normal-mode
// FIFO feeds the design. Bursts are filled in zero time, and the expected
// counts, latencies and data values are written out by hand for each burst.
// rdfull/rdempty can be forced to reproduce flag glitches.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fifo_drain_checker;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rdfull;
  logic              rdempty;
  logic [DATA_W-1:0] q_reg = '0;
  logic              rdreq;
  logic              busy;
  logic              burst_done;
  logic              err;
  logic [DATA_W-1:0] last_data;
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  burst_cnt;
  logic [CNT_W-1:0]  err_cnt;

  int n_vec    = 0;
  int n_miscmp = 0;

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // FIFO model: writes from the stimulus, reads clocked by rdreq
  // ---------------------------------------------------------------------------
  logic [7:0] mem [0:255];
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  int         underflow = 0;
  logic       fifo_clr = 1'b0;
  logic       force_full = 1'b0;
  logic       force_empty = 1'b0;

  assign rdfull  = force_full  || ((wr_cnt - rd_cnt) == 256);
  assign rdempty = force_empty || (wr_cnt == rd_cnt);

  always @(posedge clk) begin
    if (fifo_clr) begin
      rd_cnt <= wr_cnt;
    end else if (rdreq) begin
      if (wr_cnt == rd_cnt) begin
        underflow <= underflow + 1;
      end else begin
        q_reg  <= mem[rd_cnt[7:0]];
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  fifo_drain_checker #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rdfull     (rdfull),
    .i_rdempty    (rdempty),
    .i_q          (q_reg),
    .o_rdreq      (rdreq),
    .o_busy       (busy),
    .o_burst_done (burst_done),
    .o_err        (err),
    .o_last_data  (last_data),
    .o_word_cnt   (word_cnt),
    .o_burst_cnt  (burst_cnt),
    .o_err_cnt    (err_cnt)
  );

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end else begin
      $display("pass %s: 0x%0h", tag, obs);
    end
  endtask

  // Writes 256 words seed, seed+1, ... with word bad_idx replaced by bad_val.
  task automatic fill(input logic [7:0] seed, input int bad_idx,
                      input logic [7:0] bad_val);
    logic [7:0] d;
    for (int i = 0; i < 256; i++) begin
      d = seed + 8'(i);
      if (i == bad_idx) d = bad_val;
      mem[wr_cnt[7:0]] = d;
      wr_cnt++;
    end
  endtask

  // Reset the DUT for one cycle and flush the FIFO model.
  task automatic pulse_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    fifo_clr = 1'b1;
    @(negedge clk);
    rst_n    = 1'b1;
    fifo_clr = 1'b0;
  endtask

  // Watches one burst at negedges until burst_done (bounded), then one more
  // cycle to confirm the return to IDLE. Cycle 1 is the first after the fill.
  task automatic run_burst(input string tag, output int n_req, output int n_err,
                           output int n_busy, output int first_req,
                           output int first_err, output int empty_to_done);
    int cyc, first_empty, done_cyc;
    n_req = 0; n_err = 0; n_busy = 0;
    first_req = -1; first_err = -1; first_empty = -1; done_cyc = -1;
    cyc = 0;
    while (done_cyc < 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (rdreq) begin
        n_req++;
        if (first_req < 0) first_req = cyc;
      end
      if (err) begin
        n_err++;
        if (first_err < 0) first_err = cyc;
      end
      if (busy) n_busy++;
      if (busy && rdempty && first_empty < 0) first_empty = cyc;
      if (burst_done) done_cyc = cyc;
    end
    check_val({tag, "_burst_done_seen"}, 32'(done_cyc > 0), 32'd1);
    empty_to_done = done_cyc - first_empty;
    @(negedge clk);
    check_val({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rdreq"},      32'(rdreq),      32'd0);
    check_val({tag, "_busy"},       32'(busy),       32'd0);
    check_val({tag, "_burst_done"}, 32'(burst_done), 32'd0);
    check_val({tag, "_err"},        32'(err),        32'd0);
    check_val({tag, "_last_data"},  32'(last_data),  32'd0);
    check_val({tag, "_word_cnt"},   32'(word_cnt),   32'd0);
    check_val({tag, "_burst_cnt"},  32'(burst_cnt),  32'd0);
    check_val({tag, "_err_cnt"},    32'(err_cnt),    32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n_req, n_err, n_busy, first_req, first_err, e2d;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("reset");

    // Burst 1: 0x00..0xFF from a full FIFO.
    @(negedge clk);
    fill(8'h00, -1, 8'h00);
    run_burst("b1", n_req, n_err, n_busy, first_req, first_err, e2d);
    check_val("b1_rdreq_cycles", 32'(n_req), 32'd256);
    check_val("b1_first_rdreq_lat", 32'(first_req), 32'd1);
    check_val("b1_busy_cycles", 32'(n_busy), 32'd259);
    check_val("b1_empty_to_done", 32'(e2d), 32'd2);
    check_val("b1_err_pulses", 32'(n_err), 32'd0);
    check_val("b1_word_cnt", 32'(word_cnt), 32'd256);
    check_val("b1_err_cnt", 32'(err_cnt), 32'd0);
    check_val("b1_burst_cnt", 32'(burst_cnt), 32'd1);
    check_val("b1_last_data", 32'(last_data), 32'h0FF);

    // Burst 2: 0xF0..0xFF, 0x00..0xEF crosses the wrap.
    fill(8'hF0, -1, 8'h00);
    run_burst("b2", n_req, n_err, n_busy, first_req, first_err, e2d);
    check_val("b2_err_pulses", 32'(n_err), 32'd0);
    check_val("b2_err_cnt", 32'(err_cnt), 32'd0);
    check_val("b2_last_data", 32'(last_data), 32'h0EF);
    check_val("b2_burst_cnt", 32'(burst_cnt), 32'd2);

    // Burst 3: word 10 corrupted to 0x55.
    fill(8'h00, 10, 8'h55);
`ifdef FIFO_CHK_STOP_ON_ERR_EN
    n_err = 0;
    n_req = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (err) n_err++;
      if (burst_done) n_req++;
    end
    check_val("b3h_err_pulses", 32'(n_err), 32'd1);
    check_val("b3h_done_pulses", 32'(n_req), 32'd0);
    check_val("b3h_busy", 32'(busy), 32'd1);
    check_val("b3h_rdreq", 32'(rdreq), 32'd0);
    check_val("b3h_err_cnt", 32'(err_cnt), 32'd1);
    check_val("b3h_burst_cnt", 32'(burst_cnt), 32'd2);
    check_val("b3h_last_data", 32'(last_data), 32'h00B);
`else
    run_burst("b3", n_req, n_err, n_busy, first_req, first_err, e2d);
    check_val("b3_err_pulses", 32'(n_err), 32'd2);
    check_val("b3_first_err_cycle", 32'(first_err), 32'd13);
    check_val("b3_err_cnt", 32'(err_cnt), 32'd2);
    check_val("b3_burst_cnt", 32'(burst_cnt), 32'd3);
    check_val("b3_last_data", 32'(last_data), 32'h0FF);
`endif

    // Three back-to-back bursts seeded 0x40, then one with an unrelated seed
    // whose first word must not be checked.
    pulse_reset();
    check_val("b4_reset_burst_cnt", 32'(burst_cnt), 32'd0);
    check_val("b4_reset_err_cnt", 32'(err_cnt), 32'd0);
    for (int b = 0; b < 3; b++) begin
      fill(8'h40, -1, 8'h00);
      run_burst("b4", n_req, n_err, n_busy, first_req, first_err, e2d);
    end
    check_val("b4_burst_cnt", 32'(burst_cnt), 32'd3);
    check_val("b4_err_cnt", 32'(err_cnt), 32'd0);
    fill(8'h13, -1, 8'h00);
    run_burst("b5", n_req, n_err, n_busy, first_req, first_err, e2d);
    check_val("b5_first_word_unchecked", 32'(err_cnt), 32'd0);
    check_val("b5_burst_cnt", 32'(burst_cnt), 32'd4);
    check_val("b5_last_data", 32'(last_data), 32'h012);

    // Reset after 20 reads of a burst.
    fill(8'h00, -1, 8'h00);
    n_req = 0;
    for (int c = 0; c < 100 && n_req < 20; c++) begin
      @(negedge clk);
      if (rdreq) n_req++;
    end
    check_val("b6_reads_before_reset", 32'(n_req), 32'd20);
    rst_n    = 1'b0;
    fifo_clr = 1'b1;
    @(negedge clk);
    check_reset_outputs("b6_midreset");
    rst_n    = 1'b1;
    fifo_clr = 1'b0;
    @(negedge clk);
    check_val("b6_inflight_dropped", 32'(word_cnt), 32'd0);
    fill(8'h77, -1, 8'h00);
    run_burst("b7", n_req, n_err, n_busy, first_req, first_err, e2d);
    check_val("b7_word_cnt", 32'(word_cnt), 32'd256);
    check_val("b7_burst_cnt", 32'(burst_cnt), 32'd1);
    check_val("b7_err_cnt", 32'(err_cnt), 32'd0);
    check_val("b7_last_data", 32'(last_data), 32'h076);

    // Flag glitch: rdfull pulses while rdempty is held high.
    force_empty = 1'b1;
    force_full  = 1'b1;
    n_req = 0;
    e2d   = -1;
    for (int c = 1; c <= 8 && e2d < 0; c++) begin
      @(negedge clk);
      force_full = 1'b0;
      if (rdreq) n_req++;
      if (burst_done) e2d = c;
    end
    check_val("b8_no_rdreq", 32'(n_req), 32'd0);
    check_val("b8_done_latency", 32'(e2d), 32'd3);
    @(negedge clk);
    force_empty = 1'b0;
    check_val("b8_burst_cnt", 32'(burst_cnt), 32'd2);
    check_val("b8_word_cnt", 32'(word_cnt), 32'd0);

    check_val("fifo_underflow", 32'(underflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "simulation timeout");
  end

endmodule

// File: doc/fifo_drain_checker.md
# fifo_drain_checker

Read-side consumer for the 8-bit single-clock FIFO. It waits until the FIFO reports full, then drains it to empty in one burst. Each word is checked against an increment-by-one sequence (mod 256), and the block counts bursts and mismatches. It drives the FIFO's `rdreq` and consumes `q`, `rdfull` and `rdempty`, replacing the free-running read stage.

## Interface
- `DATA_W`, 8, width of FIFO data word `q`
- `CNT_W`, 16, width of `burst_cnt`, `err_cnt` and `word_cnt`
- `clk`  in  1  single clock, rising edge; also the FIFO's `rdclk`
- `rst_n`  in  1  reset, synchronous, active-low
- `rdfull`  in  1  FIFO read-side full flag
- `rdempty`  in  1  FIFO read-side empty flag
- `q`  in  DATA_W  FIFO read data; valid one cycle after `rdreq` (normal, non-show-ahead mode)
- `rdreq`  out  1  FIFO read request
- `busy`  out  1  high in any state other than IDLE
- `burst_done`  out  1  one-cycle pulse at the end of each burst
- `err`  out  1  one-cycle pulse on each data mismatch
- `last_data`  out  DATA_W  last word read from the FIFO
- `word_cnt`  out  CNT_W  number of words read in the current or most recent burst
- `burst_cnt`  out  CNT_W  number of completed bursts; saturates at all-ones
- `err_cnt`  out  CNT_W  total number of mismatches; saturates at all-ones

## Operation
- FSM states: IDLE, DRAIN, TAIL, DONE, plus HALT when the config macro is set.
- IDLE → DRAIN when `rdfull`=1. On entry: `word_cnt`←0, first-word flag set.
- DRAIN
  - `rdreq` = (state==DRAIN) && !`rdempty`, combinational.
  - → TAIL on the first cycle with `rdempty`=1.
- TAIL: `rdreq`=0. Lasts one cycle so the final `q` can be captured, then → DONE.
- DONE: `burst_done`=1 for one cycle, `burst_cnt`+1 (saturating), then → IDLE.
- `rd_vld` is `rdreq` registered by one cycle. On each cycle with `rd_vld`=1:
  - `last_data`←`q`, `word_cnt`+1 (saturating).
  - If the first-word flag is set: clear it, `exp`←`q`+1 (mod 2^DATA_W), no check.
  - Otherwise, if `q`≠`exp`: `err`=1 for that cycle, `err_cnt`+1 (saturating). In both cases `exp`←`q`+1, so the sequence resynchronises on the received value.
- The expected value wraps: 8'hFF followed by 8'h00 is correct.
- `rdfull` seen in DRAIN, TAIL or DONE is ignored. A new burst needs a return to IDLE.
- `rdempty`=1 already on the first DRAIN cycle (a flag glitch) gives zero reads; the burst still completes and `burst_cnt` increments.

## Timing
- Reset (`rst_n`=0 at a rising edge): state←IDLE, `rdreq`=0, `busy`=0, `burst_done`=0, `err`=0, `last_data`=0, `word_cnt`=0, `burst_cnt`=0, `err_cnt`=0, `exp`=0, `rd_vld`=0.
- Reset mid-burst aborts immediately. A word in flight (`rd_vld`) is discarded and not counted.
- Latency from `rdfull` rising (sampled in IDLE) to the first `rdreq`: 1 cycle.
- Read-to-check latency: 1 cycle (`rdreq` at edge N, `q` checked at edge N+1, `err` visible after edge N+1).
- From the first `rdempty`=1 in DRAIN to `burst_done`: 2 cycles (TAIL, then DONE).
- Throughput: one word per cycle while `rdempty`=0.
- A burst of N words from a full FIFO takes N+3 cycles from the IDLE→DRAIN transition until IDLE is re-entered.
- Underflow protection relies on `rdreq` being gated by `rdempty`. The FIFO's own underflow checking stays enabled.

## Configuration
- `FIFO_CHK_STOP_ON_ERR_EN`
  - Defined: the first mismatch moves the FSM from DRAIN or TAIL to HALT. In HALT, `rdreq`=0 and `busy`=1; `burst_done` never pulses and `burst_cnt` does not increment. The only exit is reset. `err_cnt` stops at 1. A word already in flight when HALT is entered is captured into `last_data` but not checked.
  - Not defined: there is no HALT state. Mismatches are counted and draining continues.

## Test plan
- Fill the FIFO to full (depth 256) with 0x00..0xFF, then let it drain. Required: 256 `rdreq` cycles, `word_cnt`=256, `err_cnt`=0, `burst_cnt`=1, `last_data`=0xFF, `burst_done` 2 cycles after `rdempty` rises.
- Fill with 0xF0..0xFF then 0x00..0xEF (wrap). Required: `err_cnt`=0, `last_data`=0xEF.
- Fill with an increasing sequence except word 10 = 0x55 (expected 0x0A). Required: `err` pulses twice (at 0x55, and at the next word 0x0B vs expected 0x56), `err_cnt`=2. With `FIFO_CHK_STOP_ON_ERR_EN` defined: HALT after the first error, `err_cnt`=1, `rdreq` held at 0, `burst_cnt`=0.
- Three back-to-back full bursts, each starting at seed 0x40. Required: `burst_cnt`=3, `err_cnt`=0; the first word of each burst is not checked.
- Assert `rst_n`=0 for one cycle after 20 reads of a burst. Required: all outputs return to reset values the next cycle, `rdreq`=0; the next `rdfull` starts a fresh burst with `word_cnt` restarting from 0.
- Hold `rdempty`=1 and pulse `rdfull`=1 in IDLE. Required: no `rdreq`, `burst_done` 3 cycles later, `burst_cnt`=1, `word_cnt`=0.
